// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the decode/scoreboard stage.
//   - instruction field positions inside the 32-bit IR
//   - opcode constants
//   - condition-code encodings {neg,zero,pos}
//   - instruction-class record produced by decode_classify
//   - saturating counter helper used by the pending-write trackers
package decode_pkg;

  localparam int OPC_LO  = 24;
  localparam int OPC_W   = 8;
  localparam int DEST_LO = 20;
  localparam int SRC1_LO = 16;
  localparam int SRC2_LO = 8;
  localparam int IMM_LO  = 0;
  localparam int IMM_W   = 16;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_AND  = 8'h02;
  localparam logic [7:0] OP_ADDI = 8'h03;
  localparam logic [7:0] OP_MOVI = 8'h04;
  localparam logic [7:0] OP_LDW  = 8'h05;
  localparam logic [7:0] OP_STW  = 8'h06;
  localparam logic [7:0] OP_BRZ  = 8'h07;
  localparam logic [7:0] OP_BRN  = 8'h08;
  localparam logic [7:0] OP_JMP  = 8'h09;

  localparam logic [2:0] CC_NEG  = 3'b100;
  localparam logic [2:0] CC_ZERO = 3'b010;
  localparam logic [2:0] CC_POS  = 3'b001;

  typedef struct packed {
    logic uses_src1;
    logic uses_src2;
    logic writes_dest;
    logic sets_cc;
    logic is_branch;
  } iclass_t;

  // cur + inc - dec, clamped to [0, maxv]. The low clamp keeps a stray
  // writeback from wrapping a counter to "full"; the high clamp only
  // matters for the CC counter, which has no stall guarding its increment.
  function automatic int sat_update(input int cur, input int inc,
                                    input int dec, input int maxv);
    int t;
    t = cur + inc - dec;
    if (t < 0)    t = 0;
    if (t > maxv) t = maxv;
    return t;
  endfunction

  function automatic logic [2:0] cc_encode(input logic neg, input logic zero);
    if (neg)       return CC_NEG;
    else if (zero) return CC_ZERO;
    else           return CC_POS;
  endfunction

endpackage

// File: rtl/SignExtension.sv
// SignExtension: widen a two's-complement value from IN_W to OUT_W bits.
//   I_In  : IN_W-bit input
//   O_Out : OUT_W-bit sign-extended result (OUT_W >= IN_W)
module SignExtension #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  I_In,
  output logic [OUT_W-1:0] O_Out
);

  assign O_Out = OUT_W'($signed(I_In));

endmodule

// File: rtl/decode_classify.sv
// decode_classify: opcode -> instruction class flags. This table is the
// single source of truth for which operands an instruction reads/writes.
// Unknown opcodes decode to all-zero flags (behave as NOP for hazards).
//   opcode_i : 8-bit opcode
//   cls_o    : class record {uses_src1, uses_src2, writes_dest, sets_cc, is_branch}
module decode_classify
  import decode_pkg::*;
(
  input  logic [7:0] opcode_i,
  output iclass_t    cls_o
);

  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OP_ADD, OP_AND: cls_o = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      OP_ADDI:        cls_o = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      OP_MOVI:        cls_o = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      OP_LDW:         cls_o = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      OP_STW:         cls_o = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      OP_BRZ, OP_BRN: cls_o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      OP_JMP:         cls_o = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      default:        cls_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: decode stage with register file, per-register
// pending-write scoreboard and condition-code tracking.
//   I_CLOCK / I_RESET          : clock, async active-high reset
//   I_LOCK, I_PC, I_IR         : fetch slot (valid, PC, instruction)
//   I_FetchStall               : fetch bubble marker
//   I_WBEnable/RegIdx/Data/SetCC : NUM_WB independent writeback ports
//   O_LOCK..O_DepStall         : registered decoded slot (1-cycle latency)
//   O_DepStallSignal           : combinational hazard stall to fetch
//   O_BranchStallSignal        : combinational branch-in-decode to fetch
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int NUM_RF    = 16,
  parameter int REG_WIDTH = 16,
  parameter int PC_WIDTH  = 16,
  parameter int NUM_WB    = 2,
  parameter int PEND_W    = 2
) (
  input  logic                                I_CLOCK,
  input  logic                                I_RESET,
  input  logic                                I_LOCK,
  input  logic [PC_WIDTH-1:0]                 I_PC,
  input  logic [31:0]                         I_IR,
  input  logic                                I_FetchStall,
  input  logic [NUM_WB-1:0]                   I_WBEnable,
  input  logic [NUM_WB*$clog2(NUM_RF)-1:0]    I_WBRegIdx,
  input  logic [NUM_WB*REG_WIDTH-1:0]         I_WBData,
  input  logic [NUM_WB-1:0]                   I_WBSetCC,
  output logic                                O_LOCK,
  output logic [PC_WIDTH-1:0]                 O_PC,
  output logic [7:0]                          O_Opcode,
  output logic [REG_WIDTH-1:0]                O_Src1Value,
  output logic [REG_WIDTH-1:0]                O_Src2Value,
  output logic [$clog2(NUM_RF)-1:0]           O_DestRegIdx,
  output logic [REG_WIDTH-1:0]                O_Imm,
  output logic                                O_FetchStall,
  output logic                                O_DepStall,
  output logic                                O_DepStallSignal,
  output logic                                O_BranchStallSignal
);

  localparam int RI_W     = $clog2(NUM_RF);
  localparam int HIT_W    = $clog2(NUM_WB + 1);
  localparam int PEND_MAX = (1 << PEND_W) - 1;

  // ---- field extraction ----
  logic [OPC_W-1:0]     opcode;
  logic [RI_W-1:0]      dest, src1, src2;
  logic [REG_WIDTH-1:0] imm;
  iclass_t              cls;

  assign opcode = I_IR[OPC_LO  +: OPC_W];
  assign dest   = I_IR[DEST_LO +: RI_W];
  assign src1   = I_IR[SRC1_LO +: RI_W];
  assign src2   = I_IR[SRC2_LO +: RI_W];

  decode_classify u_classify (
    .opcode_i (opcode),
    .cls_o    (cls)
  );

  SignExtension #(.IN_W(IMM_W), .OUT_W(REG_WIDTH)) u_sext (
    .I_In  (I_IR[IMM_LO +: IMM_W]),
    .O_Out (imm)
  );

  logic [NUM_WB-1:0][RI_W-1:0]      wb_idx;
  logic [NUM_WB-1:0][REG_WIDTH-1:0] wb_data;
  assign wb_idx  = I_WBRegIdx;
  assign wb_data = I_WBData;

  // ---- architectural / tracking state ----
  logic [NUM_RF-1:0][REG_WIDTH-1:0] rf_q, rf_d;
  logic [NUM_RF-1:0][PEND_W-1:0]    pend_q, pend_d;
  logic [PEND_W-1:0]                cc_pend_q, cc_pend_d;
  logic [2:0]                       cc_q, cc_d;

  // Writebacks landing on each register (and on CC) this cycle.
  logic [NUM_RF-1:0][HIT_W-1:0] hits;
  logic [HIT_W-1:0]             cc_hits;

  always_comb begin
    hits    = '0;
    cc_hits = '0;
    for (int p = 0; p < NUM_WB; p++) begin
      if (I_WBEnable[p]) begin
        hits[wb_idx[p]] = hits[wb_idx[p]] + HIT_W'(1);
        if (I_WBSetCC[p]) cc_hits = cc_hits + HIT_W'(1);
      end
    end
  end

  // ---- hazard detection ----
  // A source is free if every outstanding write to it lands this cycle;
  // the bypass below then supplies the fresh value. Destination fullness
  // looks at the raw count so the increment can never overflow.
  logic slot, src1_busy, src2_busy, dest_full, cc_busy, dep_stall, issue;

  assign slot      = I_LOCK & ~I_FetchStall;
  assign src1_busy = int'(pend_q[src1]) > int'(hits[src1]);
  assign src2_busy = int'(pend_q[src2]) > int'(hits[src2]);
  assign dest_full = int'(pend_q[dest]) == PEND_MAX;
  assign cc_busy   = cc_pend_q != '0;

  assign dep_stall = slot & ((cls.uses_src1   & src1_busy) |
                             (cls.uses_src2   & src2_busy) |
                             (cls.writes_dest & dest_full) |
                             (cls.is_branch   & cc_busy));
  assign issue     = slot & ~dep_stall;

  assign O_DepStallSignal    = dep_stall;
  assign O_BranchStallSignal = slot & cls.is_branch & ~dep_stall;

  // ---- counter next state: issue increment and writeback decrements net out ----
  always_comb begin
    pend_d = '0;
    for (int r = 0; r < NUM_RF; r++) begin
      pend_d[r] = PEND_W'(sat_update(int'(pend_q[r]),
                                     (issue && cls.writes_dest && dest == RI_W'(r)) ? 1 : 0,
                                     int'(hits[r]), PEND_MAX));
    end
    cc_pend_d = PEND_W'(sat_update(int'(cc_pend_q), (issue && cls.sets_cc) ? 1 : 0,
                                   int'(cc_hits), PEND_MAX));
  end

  // ---- register file and CC writes; ascending port order so the highest port wins ----
  always_comb begin
    rf_d = rf_q;
    cc_d = cc_q;
    for (int p = 0; p < NUM_WB; p++) begin
      if (I_WBEnable[p]) begin
        rf_d[wb_idx[p]] = wb_data[p];
        if (I_WBSetCC[p])
          cc_d = cc_encode(wb_data[p][REG_WIDTH-1], wb_data[p] == '0);
      end
    end
  end

  // ---- source operand read with writeback bypass ----
  logic [REG_WIDTH-1:0] src1_val, src2_val;

  always_comb begin
    src1_val = rf_q[src1];
    src2_val = rf_q[src2];
    for (int p = 0; p < NUM_WB; p++) begin
      if (I_WBEnable[p] && wb_idx[p] == src1) src1_val = wb_data[p];
      if (I_WBEnable[p] && wb_idx[p] == src2) src2_val = wb_data[p];
    end
  end

  // ---- registered slot outputs ----
  logic                 lock_q, fstall_q, dstall_q;
  logic [PC_WIDTH-1:0]  pc_q;
  logic [7:0]           opcode_q, opcode_d;
  logic [REG_WIDTH-1:0] src1_q, src2_q, imm_q;
  logic [RI_W-1:0]      dest_q;

  // Stalled or bubbled slots travel downstream as NOPs.
  assign opcode_d = (dep_stall || I_FetchStall) ? 8'h00 : opcode;

  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      rf_q      <= '0;
      pend_q    <= '0;
      cc_pend_q <= '0;
      cc_q      <= CC_ZERO;
      lock_q    <= 1'b0;
      pc_q      <= '0;
      opcode_q  <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      dest_q    <= '0;
      imm_q     <= '0;
      fstall_q  <= 1'b0;
      dstall_q  <= 1'b0;
    end else begin
      rf_q      <= rf_d;
      pend_q    <= pend_d;
      cc_pend_q <= cc_pend_d;
      cc_q      <= cc_d;
      lock_q    <= I_LOCK;
      pc_q      <= I_PC;
      opcode_q  <= opcode_d;
      src1_q    <= src1_val;
      src2_q    <= src2_val;
      dest_q    <= dest;
      imm_q     <= imm;
      fstall_q  <= I_FetchStall;
      dstall_q  <= dep_stall;
    end
  end

  assign O_LOCK       = lock_q;
  assign O_PC         = pc_q;
  assign O_Opcode     = opcode_q;
  assign O_Src1Value  = src1_q;
  assign O_Src2Value  = src2_q;
  assign O_DestRegIdx = dest_q;
  assign O_Imm        = imm_q;
  assign O_FetchStall = fstall_q;
  assign O_DepStall   = dstall_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
module tb_decode_scoreboard;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        lock, fstall;
  logic [15:0] pc;
  logic [31:0] ir_i;
  logic [1:0]  wben, wbsc;
  logic [7:0]  wbidx;
  logic [31:0] wbdata;

  logic        O_LOCK, O_FetchStall, O_DepStall, O_DepStallSignal, O_BranchStallSignal;
  logic [15:0] O_PC, O_Src1Value, O_Src2Value, O_Imm;
  logic [7:0]  O_Opcode;
  logic [3:0]  O_DestRegIdx;

  always #5 clk = ~clk;

  decode_scoreboard #(.NUM_RF(16), .REG_WIDTH(16), .PC_WIDTH(16), .NUM_WB(2), .PEND_W(2)) dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock), .I_PC(pc), .I_IR(ir_i),
    .I_FetchStall(fstall), .I_WBEnable(wben), .I_WBRegIdx(wbidx), .I_WBData(wbdata),
    .I_WBSetCC(wbsc), .O_LOCK(O_LOCK), .O_PC(O_PC), .O_Opcode(O_Opcode),
    .O_Src1Value(O_Src1Value), .O_Src2Value(O_Src2Value), .O_DestRegIdx(O_DestRegIdx),
    .O_Imm(O_Imm), .O_FetchStall(O_FetchStall), .O_DepStall(O_DepStall),
    .O_DepStallSignal(O_DepStallSignal), .O_BranchStallSignal(O_BranchStallSignal));

  int n_cmp = 0, n_fail = 0;

  // ---------------- reference model ----------------
  int          pend_m[16];
  logic [15:0] rf_m[16];
  int          ccp_m;
  logic [2:0]  cc_m;
  logic        e_dep, e_br;
  logic [78:0] e_regs;

  function automatic logic [78:0] dut_regs();
    return {O_LOCK, O_PC, O_Opcode, O_Src1Value, O_Src2Value, O_DestRegIdx, O_Imm,
            O_FetchStall, O_DepStall};
  endfunction

  // {uses_src1, uses_src2, writes_dest, sets_cc, is_branch}
  function automatic logic [4:0] cls_of(input logic [7:0] op);
    case (op)
      OP_ADD, OP_AND: return 5'b11110;
      OP_ADDI:        return 5'b10110;
      OP_MOVI:        return 5'b00110;
      OP_LDW:         return 5'b10100;
      OP_STW:         return 5'b11000;
      OP_BRZ, OP_BRN: return 5'b00001;
      OP_JMP:         return 5'b10001;
      default:        return 5'b00000;
    endcase
  endfunction

  function automatic logic [31:0] irr(input logic [7:0] op, input logic [3:0] d, s1, s2);
    return {op, d, s1, 4'h0, s2, 8'h00};
  endfunction

  function automatic logic [31:0] iri(input logic [7:0] op, input logic [3:0] d, s1,
                                      input logic [15:0] imm);
    return {op, d, s1, imm};
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin pend_m[r] = 0; rf_m[r] = '0; end
    ccp_m = 0;
    cc_m  = 3'b010;
  endtask

  // Evaluate the current inputs against model state, then advance the state
  // as the coming rising edge will.
  task automatic model_step();
    logic [4:0]  c;
    int          d, s1, s2, n, cch, idx;
    int          hits[16];
    logic        slot, issue;
    logic [15:0] v1, v2, dv;
    c  = cls_of(ir_i[31:24]);
    d  = int'(ir_i[23:20]);
    s1 = int'(ir_i[19:16]);
    s2 = int'(ir_i[11:8]);
    for (int r = 0; r < 16; r++) hits[r] = 0;
    cch = 0;
    for (int p = 0; p < 2; p++)
      if (wben[p]) begin
        hits[wbidx[p*4 +: 4]]++;
        if (wbsc[p]) cch++;
      end
    slot  = lock && !fstall;
    e_dep = slot && ((c[4] && pend_m[s1] > hits[s1]) || (c[3] && pend_m[s2] > hits[s2]) ||
                     (c[2] && pend_m[d] == 3) || (c[0] && ccp_m != 0));
    e_br  = slot && c[0] && !e_dep;
    issue = slot && !e_dep;
    v1 = rf_m[s1];
    v2 = rf_m[s2];
    for (int p = 0; p < 2; p++)
      if (wben[p]) begin
        idx = int'(wbidx[p*4 +: 4]);
        if (idx == s1) v1 = wbdata[p*16 +: 16];
        if (idx == s2) v2 = wbdata[p*16 +: 16];
      end
    e_regs = {lock, pc, (e_dep || fstall) ? 8'h00 : ir_i[31:24], v1, v2, ir_i[23:20],
              ir_i[15:0], fstall, e_dep};
    for (int r = 0; r < 16; r++) begin
      n = pend_m[r] + ((issue && c[2] && d == r) ? 1 : 0) - hits[r];
      pend_m[r] = (n < 0) ? 0 : (n > 3 ? 3 : n);
    end
    n = ccp_m + ((issue && c[1]) ? 1 : 0) - cch;
    ccp_m = (n < 0) ? 0 : (n > 3 ? 3 : n);
    for (int p = 0; p < 2; p++)
      if (wben[p]) begin
        dv = wbdata[p*16 +: 16];
        rf_m[wbidx[p*4 +: 4]] = dv;
        if (wbsc[p]) cc_m = dv[15] ? 3'b100 : (dv == 0 ? 3'b010 : 3'b001);
      end
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic wb_clear();
    wben = '0; wbsc = '0; wbidx = '0; wbdata = '0;
  endtask

  task automatic wb(input int p, input logic [3:0] idx, input logic [15:0] d, input logic sc);
    wben[p] = 1'b1;
    wbsc[p] = sc;
    wbidx[p*4 +: 4]   = idx;
    wbdata[p*16 +: 16] = d;
  endtask

  task automatic slot_in(input logic l, input logic fs, input logic [31:0] ir);
    lock = l; fstall = fs; ir_i = ir; pc = 16'($urandom);
  endtask

  task automatic eval();
    #1; model_step();
  endtask

  task automatic edge_();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wb_clear(); slot_in(1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    slot_in(1'b1, 1'b0, irr(OP_ADD, 4'd1, 4'd2, 4'd3));
    wb_clear(); wb(0, 4'd2, 16'hBEEF, 1'b1);
    #1;
    n_cmp++; if (dut_regs() !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h exp 0", dut_regs()); end
    n_cmp++; if (O_DepStallSignal !== 1'b0) begin n_fail++; $display("FAIL reset_depsig: got %b exp 0", O_DepStallSignal); end
    edge_();
    n_cmp++; if (dut_regs() !== '0) begin n_fail++; $display("FAIL reset_held: got %h exp 0", dut_regs()); end
    rst = 1'b0; model_reset(); wb_clear();
    // writeback during reset must not have reached R2
    slot_in(1'b1, 1'b0, iri(OP_ADDI, 4'd5, 4'd2, 16'h0001));
    eval(); edge_();
    n_cmp++; if (O_Src1Value !== 16'h0000) begin n_fail++; $display("FAIL reset_wb_ignored: got %h exp 0000", O_Src1Value); end
  endtask

  task automatic test_add_issue();
    do_reset();
    slot_in(1'b1, 1'b0, irr(OP_ADD, 4'd1, 4'd2, 4'd3));
    eval();
    n_cmp++; if (O_DepStallSignal !== 1'b0) begin n_fail++; $display("FAIL add_depsig: got %b exp 0", O_DepStallSignal); end
    edge_();
    n_cmp++; if ({O_LOCK, O_Opcode, O_Src1Value, O_DestRegIdx, O_DepStall} !== {1'b1, OP_ADD, 16'h0, 4'd1, 1'b0}) begin
      n_fail++; $display("FAIL add_outputs: got %h exp %h", {O_LOCK, O_Opcode, O_Src1Value, O_DestRegIdx, O_DepStall},
                         {1'b1, OP_ADD, 16'h0, 4'd1, 1'b0}); end
  endtask

  task automatic test_bypass();
    // continues from ADD R1 in flight
    slot_in(1'b1, 1'b0, iri(OP_ADDI, 4'd4, 4'd1, 16'h0007));
    eval();
    n_cmp++; if (O_DepStallSignal !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b exp 1", O_DepStallSignal); end
    edge_();
    n_cmp++; if ({O_DepStall, O_Opcode} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL raw_nop: got %h exp %h", {O_DepStall, O_Opcode}, {1'b1, 8'h00}); end
    wb(0, 4'd1, 16'h0005, 1'b0);
    eval();
    n_cmp++; if (O_DepStallSignal !== 1'b0) begin n_fail++; $display("FAIL bypass_release: got %b exp 0", O_DepStallSignal); end
    edge_();
    n_cmp++; if ({O_Src1Value, O_Imm, O_Opcode, O_DepStall} !== {16'h0005, 16'h0007, OP_ADDI, 1'b0}) begin
      n_fail++; $display("FAIL bypass_value: got %h exp %h", {O_Src1Value, O_Imm, O_Opcode, O_DepStall}, {16'h0005, 16'h0007, OP_ADDI, 1'b0}); end
    wb_clear();
    slot_in(1'b1, 1'b0, irr(OP_STW, 4'd0, 4'd1, 4'd1));
    eval();
    n_cmp++; if (O_DepStallSignal !== 1'b0) begin n_fail++; $display("FAIL rf_after_wb_dep: got %b exp 0", O_DepStallSignal); end
    edge_();
    n_cmp++; if ({O_Src1Value, O_Src2Value} !== {16'h0005, 16'h0005}) begin n_fail++; $display("FAIL rf_after_wb: got %h exp 00050005", {O_Src1Value, O_Src2Value}); end
  endtask

  task automatic test_pend_limit();
    logic [5:0] exp_dep;
    exp_dep = 6'b011000;  // bit k = expected stall at step k
    do_reset();
    for (int k = 0; k < 6; k++) begin
      wb_clear();
      if (k == 4) wb(1, 4'd2, 16'h1234, 1'b0);
      slot_in(1'b1, 1'b0, iri(OP_LDW, 4'd2, 4'd0, 16'hFFF0));
      eval();
      n_cmp++; if (O_DepStallSignal !== exp_dep[k]) begin n_fail++; $display("FAIL pend_limit step %0d: got %b exp %b", k, O_DepStallSignal, exp_dep[k]); end
      edge_();
    end
    n_cmp++; if (O_Imm !== 16'hFFF0) begin n_fail++; $display("FAIL imm_sext: got %h exp fff0", O_Imm); end
    wb_clear();
  endtask

  task automatic test_dual_wb();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      slot_in(1'b1, 1'b0, iri(OP_LDW, 4'd7, 4'd0, 16'h0)); eval(); edge_();
    end
    slot_in(1'b1, 1'b0, iri(OP_ADDI, 4'd8, 4'd7, 16'h0001));
    wb(0, 4'd7, 16'h0011, 1'b0); wb(1, 4'd7, 16'h0022, 1'b0);
    eval();
    n_cmp++; if (O_DepStallSignal !== 1'b0) begin n_fail++; $display("FAIL dual_wb_dep: got %b exp 0", O_DepStallSignal); end
    edge_();
    n_cmp++; if (O_Src1Value !== 16'h0022) begin n_fail++; $display("FAIL dual_wb_bypass: got %h exp 0022", O_Src1Value); end
    wb_clear();
    slot_in(1'b1, 1'b0, iri(OP_ADDI, 4'd9, 4'd7, 16'h0002));
    eval();
    n_cmp++; if (O_DepStallSignal !== 1'b0) begin n_fail++; $display("FAIL dual_wb_pend0: got %b exp 0", O_DepStallSignal); end
    edge_();
    n_cmp++; if (O_Src1Value !== 16'h0022) begin n_fail++; $display("FAIL dual_wb_rf: got %h exp 0022", O_Src1Value); end
  endtask

  task automatic test_branch();
    do_reset();
    slot_in(1'b1, 1'b0, iri(OP_MOVI, 4'd5, 4'd0, 16'h0000)); eval(); edge_();
    slot_in(1'b1, 1'b0, iri(OP_BRZ, 4'd0, 4'd0, 16'h0010));
    eval();
    n_cmp++; if ({O_DepStallSignal, O_BranchStallSignal} !== 2'b10) begin n_fail++; $display("FAIL br_cc_stall: got %b exp 10", {O_DepStallSignal, O_BranchStallSignal}); end
    edge_();
    wb(1, 4'd5, 16'h0000, 1'b1);
    eval();
    n_cmp++; if (O_DepStallSignal !== 1'b1) begin n_fail++; $display("FAIL br_wb_cycle: got %b exp 1", O_DepStallSignal); end
    edge_();
    wb_clear();
    eval();
    n_cmp++; if ({O_DepStallSignal, O_BranchStallSignal} !== 2'b01) begin n_fail++; $display("FAIL br_release: got %b exp 01", {O_DepStallSignal, O_BranchStallSignal}); end
    edge_();
    n_cmp++; if (O_Opcode !== OP_BRZ) begin n_fail++; $display("FAIL br_issue_op: got %h exp %h", O_Opcode, OP_BRZ); end
    slot_in(1'b1, 1'b1, iri(OP_BRZ, 4'd0, 4'd0, 16'h0010));
    eval();
    n_cmp++; if ({O_DepStallSignal, O_BranchStallSignal} !== 2'b00) begin n_fail++; $display("FAIL br_fetchstall: got %b exp 00", {O_DepStallSignal, O_BranchStallSignal}); end
    edge_();
  endtask

  task automatic test_lock_gating();
    do_reset();
    slot_in(1'b0, 1'b0, iri(OP_LDW, 4'd6, 4'd0, 16'h0)); eval(); edge_();
    n_cmp++; if (O_LOCK !== 1'b0) begin n_fail++; $display("FAIL lock0_out: got %b exp 0", O_LOCK); end
    slot_in(1'b1, 1'b1, iri(OP_LDW, 4'd6, 4'd0, 16'h0)); eval(); edge_();
    n_cmp++; if ({O_FetchStall, O_Opcode} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL fetchstall_out: got %h exp 100", {O_FetchStall, O_Opcode}); end
    slot_in(1'b1, 1'b0, iri(OP_ADDI, 4'd1, 4'd6, 16'h0));
    eval();
    n_cmp++; if (O_DepStallSignal !== 1'b0) begin n_fail++; $display("FAIL no_issue_no_pend: got %b exp 0", O_DepStallSignal); end
    edge_();
    slot_in(1'b1, 1'b0, iri(OP_LDW, 4'd6, 4'd0, 16'h0)); eval(); edge_();
    slot_in(1'b0, 1'b0, 32'h0); wb(0, 4'd6, 16'h00C3, 1'b0); eval(); edge_();
    wb_clear();
    slot_in(1'b1, 1'b0, iri(OP_ADDI, 4'd1, 4'd6, 16'h0));
    eval();
    n_cmp++; if (O_DepStallSignal !== 1'b0) begin n_fail++; $display("FAIL lock0_decrement: got %b exp 0", O_DepStallSignal); end
    edge_();
    n_cmp++; if (O_Src1Value !== 16'h00C3) begin n_fail++; $display("FAIL lock0_wb_value: got %h exp 00c3", O_Src1Value); end
  endtask

  task automatic test_saturate();
    do_reset();
    slot_in(1'b0, 1'b0, 32'h0); wb(0, 4'd9, 16'h00AA, 1'b1); eval(); edge_();
    wb_clear();
    slot_in(1'b1, 1'b0, iri(OP_LDW, 4'd9, 4'd0, 16'h0));
    eval();
    n_cmp++; if (O_DepStallSignal !== 1'b0) begin n_fail++; $display("FAIL sat_pend_no_wrap: got %b exp 0", O_DepStallSignal); end
    edge_();
    slot_in(1'b1, 1'b0, iri(OP_ADDI, 4'd10, 4'd9, 16'h0));
    eval();
    n_cmp++; if (O_DepStallSignal !== 1'b1) begin n_fail++; $display("FAIL sat_pend_counts: got %b exp 1", O_DepStallSignal); end
    edge_();
    slot_in(1'b1, 1'b0, iri(OP_BRN, 4'd0, 4'd0, 16'h0));
    eval();
    n_cmp++; if ({O_DepStallSignal, O_BranchStallSignal} !== 2'b01) begin n_fail++; $display("FAIL sat_cc_no_wrap: got %b exp 01", {O_DepStallSignal, O_BranchStallSignal}); end
    edge_();
  endtask

  task automatic test_reset_mid();
    do_reset();
    slot_in(1'b1, 1'b0, iri(OP_LDW, 4'd3, 4'd0, 16'h0)); eval(); edge_();
    slot_in(1'b1, 1'b0, iri(OP_ADDI, 4'd4, 4'd3, 16'h0)); eval(); edge_();
    n_cmp++; if (O_DepStall !== 1'b1) begin n_fail++; $display("FAIL mid_pre_stall: got %b exp 1", O_DepStall); end
    #2; rst = 1'b1; #1;
    n_cmp++; if (dut_regs() !== '0) begin n_fail++; $display("FAIL mid_reset_async: got %h exp 0", dut_regs()); end
    n_cmp++; if (O_DepStallSignal !== 1'b0) begin n_fail++; $display("FAIL mid_reset_depsig: got %b exp 0", O_DepStallSignal); end
    model_reset();
    @(negedge clk); rst = 1'b0;
    eval();
    n_cmp++; if (O_DepStallSignal !== 1'b0) begin n_fail++; $display("FAIL mid_after_depsig: got %b exp 0", O_DepStallSignal); end
    edge_();
    n_cmp++; if ({O_DepStall, O_Opcode} !== {1'b0, OP_ADDI}) begin n_fail++; $display("FAIL mid_after_issue: got %h exp %h", {O_DepStall, O_Opcode}, {1'b0, OP_ADDI}); end
  endtask

  task automatic test_random();
    int claim[16];
    int cclaim, idx;
    logic sc;
    logic [7:0] op;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      wb_clear();
      for (int r = 0; r < 16; r++) claim[r] = 0;
      cclaim = 0;
      // writebacks only retire writes the model knows are outstanding
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 1) == 1) begin
          idx = $urandom_range(0, 7);
          if (pend_m[idx] > claim[idx]) begin
            claim[idx]++;
            sc = (ccp_m > cclaim) && ($urandom_range(0, 1) == 1);
            if (sc) cclaim++;
            wb(p, 4'(idx), 16'($urandom), sc);
          end
        end
      op = 8'($urandom_range(0, 10));
      if (op == 8'd10) op = 8'hC3;
      slot_in($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom);
      ir_i[31:24] = op; ir_i[23] = 1'b0; ir_i[19] = 1'b0; ir_i[11] = 1'b0;
      eval();
      n_cmp++; if ({O_DepStallSignal, O_BranchStallSignal} !== {e_dep, e_br}) begin
        n_fail++; $display("FAIL rand_comb cyc %0d: got %b exp %b", cyc, {O_DepStallSignal, O_BranchStallSignal}, {e_dep, e_br}); end
      edge_();
      n_cmp++; if (dut_regs() !== e_regs) begin
        n_fail++; $display("FAIL rand_regs cyc %0d: got %h exp %h", cyc, dut_regs(), e_regs); end
    end
    wb_clear();
  endtask

  initial begin
    model_reset();
    wb_clear();
    test_reset();
    test_add_issue();
    test_bypass();
    test_pend_limit();
    test_dual_wb();
    test_branch();
    test_lock_gating();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
